alu_sequencer: RTL and testbench

Issue-side controller for the 8-bit `alu`. It accepts 8-bit instructions over a valid/ready handshake and decodes them into ALU controls (`a`, `b`, `imm`, `opcode`). It reads operands from a private 4×8 register file, waits out the ALU's registered latency, captures the ALU `result` and writes it back. It sits between the instruction source and the `alu` instance.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: instruction field layout,
// opcode values, register-file geometry and the controller state type.
package alu_pkg;

  localparam int          INSTR_W = 8;
  localparam int          REG_W   = 8;
  localparam int unsigned NREGS   = 4;
  localparam int          ADDR_W  = $clog2(NREGS);

  localparam int OPC_BIT = 7;
  localparam int RD_MSB  = 6;
  localparam int RD_LSB  = 5;
  localparam int RS_MSB  = 4;
  localparam int RS_LSB  = 3;
  localparam int IMM_MSB = 2;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SHL = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    WB   = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic              opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [IMM_W-1:0]  imm;
  } instr_t;

  // Split a raw instruction word into its fields.
  function automatic instr_t decode(input logic [INSTR_W-1:0] i);
    instr_t d;
    d.opcode = (i[OPC_BIT] == OP_ADD) ? OP_ADD : OP_SHL;
    d.rd     = i[RD_MSB:RD_LSB];
    d.rs     = i[RS_MSB:RS_LSB];
    d.imm    = i[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake and register-file load port between the instruction
// source (master) and the sequencer (slave).
interface alu_sequencer_if;
  import alu_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic               ld_valid;
  logic [ADDR_W-1:0]  ld_addr;
  logic [REG_W-1:0]   ld_data;

  modport master (
    output instr_valid,
    output instr,
    output ld_valid,
    output ld_addr,
    output ld_data,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    output instr_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// 4x8 register file: one synchronous write port, two operand read ports and a
// debug read port, all reads combinational; asynchronous clear to zero.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [REG_W-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [REG_W-1:0]  rdata_b,
  input  logic [ADDR_W-1:0] raddr_d,
  output logic [REG_W-1:0]  rdata_d
);

  logic [REG_W-1:0] regs [NREGS];

  // Storage: clear on reset, otherwise single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side controller for the 8-bit ALU: accepts instructions, drives the
// ALU with register operands, waits out the ALU latency and writes the
// result back into the private register file.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic              sysclk,
  input  logic              rst_n,
  alu_sequencer_if.slave    instr_bus,
  output logic [REG_W-1:0]  alu_a,
  output logic [REG_W-1:0]  alu_b,
  output logic [IMM_W-1:0]  alu_imm,
  output logic              alu_opcode,
  input  logic [REG_W-1:0]  alu_result,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [REG_W-1:0]  wb_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [REG_W-1:0]  rd_data,
  output logic              busy
);

  localparam int               CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LATENCY - 1);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] rd_q;
  instr_t            dec;
  logic              accept;
  logic              load_en;
  logic              in_wb;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [REG_W-1:0]  rf_wdata;
  logic [REG_W-1:0]  rf_a;
  logic [REG_W-1:0]  rf_b;

  assign dec     = decode(instr_bus.instr);
  // A load in IDLE blocks the instruction for that cycle; it stays pending.
  assign instr_bus.instr_ready = (state == IDLE) && !instr_bus.ld_valid && rst_n;
  assign accept  = instr_bus.instr_valid && instr_bus.instr_ready;
  assign load_en = (state == IDLE) && instr_bus.ld_valid;
  assign in_wb   = (state == WB);
  assign busy    = (state != IDLE);

  // Register-file write source: writeback in WB, external load in IDLE only.
  always_comb begin
    rf_we    = load_en || in_wb;
    rf_waddr = instr_bus.ld_addr;
    rf_wdata = instr_bus.ld_data;
    if (in_wb) begin
      rf_waddr = rd_q;
      rf_wdata = alu_result;
    end
  end

  alu_regfile u_regfile (
    .clk     (sysclk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (dec.rd),
    .rdata_a (rf_a),
    .raddr_b (dec.rs),
    .rdata_b (rf_b),
    .raddr_d (rd_addr),
    .rdata_d (rd_data)
  );

  // State register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> WAIT on accept, WAIT until counter hits 0, WB -> IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter: loaded on accept, counts down while waiting.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // ALU operand registers: captured on accept and held until the next one.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_imm    <= '0;
      alu_opcode <= 1'b0;
    end else if (accept) begin
      rd_q       <= dec.rd;
      alu_a      <= rf_a;
      alu_b      <= rf_b;
      alu_imm    <= dec.imm;
      alu_opcode <= dec.opcode;
    end
  end

  // Writeback report: one-cycle valid pulse, address/data held until next writeback.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= in_wb;
      if (in_wb) begin
        wb_addr <= rd_q;
        wb_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (ALU latency 1 and 3), each fed by a
// behavioural delayed-result ALU, checked against a register-file model.
module tb_alu_sequencer;

  logic       sysclk;
  logic       rstn  [2];
  logic       iv    [2];
  logic [7:0] ins   [2];
  logic       lv    [2];
  logic [1:0] la    [2];
  logic [7:0] ldat  [2];
  logic [1:0] rda   [2];
  logic [7:0] a_o   [2];
  logic [7:0] b_o   [2];
  logic [2:0] imm_o [2];
  logic       op_o  [2];
  logic [7:0] res   [2];
  logic       wbv   [2];
  logic [1:0] wba   [2];
  logic [7:0] wbd   [2];
  logic [7:0] rdd   [2];
  logic       bsy   [2];
  logic       rdy   [2];

  logic [7:0] m [2][4];
  int n_chk  = 0;
  int n_pass = 0;

  alu_sequencer_if bus0 ();
  alu_sequencer_if bus1 ();

  assign bus0.instr_valid = iv[0];
  assign bus0.instr       = ins[0];
  assign bus0.ld_valid    = lv[0];
  assign bus0.ld_addr     = la[0];
  assign bus0.ld_data     = ldat[0];
  assign rdy[0]           = bus0.instr_ready;
  assign bus1.instr_valid = iv[1];
  assign bus1.instr       = ins[1];
  assign bus1.ld_valid    = lv[1];
  assign bus1.ld_addr     = la[1];
  assign bus1.ld_data     = ldat[1];
  assign rdy[1]           = bus1.instr_ready;

  alu_sequencer #(.ALU_LATENCY(1)) dut_l1 (
    .sysclk(sysclk), .rst_n(rstn[0]), .instr_bus(bus0),
    .alu_a(a_o[0]), .alu_b(b_o[0]), .alu_imm(imm_o[0]), .alu_opcode(op_o[0]),
    .alu_result(res[0]), .wb_valid(wbv[0]), .wb_addr(wba[0]), .wb_data(wbd[0]),
    .rd_addr(rda[0]), .rd_data(rdd[0]), .busy(bsy[0])
  );

  alu_sequencer #(.ALU_LATENCY(3)) dut_l3 (
    .sysclk(sysclk), .rst_n(rstn[1]), .instr_bus(bus1),
    .alu_a(a_o[1]), .alu_b(b_o[1]), .alu_imm(imm_o[1]), .alu_opcode(op_o[1]),
    .alu_result(res[1]), .wb_valid(wbv[1]), .wb_addr(wba[1]), .wb_data(wbd[1]),
    .rd_addr(rda[1]), .rd_data(rdd[1]), .busy(bsy[1])
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] imm, input logic op);
    return op ? 8'(a + b) : 8'(b << imm);
  endfunction

  // Stand-in ALUs with registered latency 1 and 3.
  logic [7:0] pipe1 [1];
  logic [7:0] pipe3 [3];
  always @(posedge sysclk) begin
    pipe1[0] <= alu_f(a_o[0], b_o[0], imm_o[0], op_o[0]);
    pipe3[0] <= alu_f(a_o[1], b_o[1], imm_o[1], op_o[1]);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign res[0] = pipe1[0];
  assign res[1] = pipe3[2];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic peek(input int d, input logic [1:0] a, output logic [7:0] v);
    rda[d] = a;
    #1;
    v = rdd[d];
  endtask

  task automatic load(input int d, input logic [1:0] a, input logic [7:0] v);
    @(negedge sysclk);
    lv[d] = 1'b1; la[d] = a; ldat[d] = v;
    @(negedge sysclk);
    lv[d] = 1'b0;
    m[d][a] = v;
  endtask

  // Issue one instruction, time its writeback and check it against the model.
  // With poke set, a load to r3 is offered during WAIT and must be ignored.
  task automatic run(input int d, input logic [7:0] i, input bit poke, output logic [7:0] wd);
    logic [1:0] rd, rs;
    logic [7:0] exp, v;
    int g, lat;
    rd  = i[6:5];
    rs  = i[4:3];
    exp = i[7] ? 8'(m[d][rd] + m[d][rs]) : 8'(m[d][rs] << i[2:0]);
    ins[d] = i; iv[d] = 1'b1;
    #1;
    g = 0;
    while (!rdy[d] && g < 50) begin @(negedge sysclk); #1; g++; end
    @(negedge sysclk);
    iv[d] = 1'b0;
    if (poke) begin lv[d] = 1'b1; la[d] = 2'd3; ldat[d] = 8'hEE; end
    #1;
    lat = 1;
    while (!wbv[d] && lat < 50) begin @(negedge sysclk); lv[d] = 1'b0; #1; lat++; end
    lv[d] = 1'b0;
    check("wb_latency", lat, lat_of(d) + 2);
    check("wb_addr", wba[d], rd);
    check("wb_data", wbd[d], exp);
    wd = wbd[d];
    m[d][rd] = exp;
    @(negedge sysclk);
    #1;
    check("wb_pulse", wbv[d], 0);
    peek(d, rd, v);
    check("rd_after_wb", v, exp);
  endtask

  initial begin
    logic [7:0] wd, v;
    int prev, nacc;
    bit seen;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; iv[d] = 1'b0; ins[d] = '0; lv[d] = 1'b0;
      la[d] = '0; ldat[d] = '0; rda[d] = '0;
      for (int r = 0; r < 4; r++) m[d][r] = '0;
    end

    // Reset values.
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", rdy[d], 0);
      check("rst_busy", bsy[d], 0);
      check("rst_wb_valid", wbv[d], 0);
      check("rst_outputs", {a_o[d], b_o[d], imm_o[d], op_o[d], wba[d], wbd[d], rdd[d]}, 0);
    end
    @(negedge sysclk);
    @(negedge sysclk);
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    #1;
    check("rel_ready_l1", rdy[0], 1);
    check("rel_ready_l3", rdy[1], 1);

    // Load and add, latency 1.
    load(0, 2'd0, 8'h12);
    load(0, 2'd1, 8'h34);
    run(0, 8'h88, 0, wd);
    check("add_wb_data", wd, 8'h46);
    peek(0, 2'd0, v);
    check("add_rd0", v, 8'h46);
    check("alu_a_held", a_o[0], 8'h12);
    check("alu_b_held", b_o[0], 8'h34);

    // Shift with truncation.
    load(0, 2'd2, 8'hC3);
    run(0, 8'h33, 0, wd);
    check("shl_trunc", wd, 8'h18);

    // Wraparound add with rd == rs.
    load(0, 2'd3, 8'h80);
    run(0, 8'hF8, 0, wd);
    check("add_wrap", wd, 8'h00);

    // Back-to-back with instr_valid held high: one accept per 3 cycles.
    @(negedge sysclk);
    ins[0] = 8'h88; iv[0] = 1'b1;
    prev = 0; nacc = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rdy[0]) begin
        if (nacc > 0) check("b2b_gap", c - prev, 3);
        prev = c; nacc++;
        m[0][0] = 8'(m[0][0] + m[0][1]);
      end
      @(negedge sysclk);
    end
    iv[0] = 1'b0;
    check("b2b_count", nacc, 4);
    @(negedge sysclk);
    @(negedge sysclk);
    peek(0, 2'd0, v);
    check("b2b_r0", v, m[0][0]);

    // Load and instruction together in IDLE: load wins, instruction waits.
    @(negedge sysclk);
    lv[0] = 1'b1; la[0] = 2'd2; ldat[0] = 8'h5A;
    ins[0] = 8'h90; iv[0] = 1'b1;
    #1;
    check("ld_prio_ready", rdy[0], 0);
    @(negedge sysclk);
    lv[0] = 1'b0;
    m[0][2] = 8'h5A;
    peek(0, 2'd2, v);
    check("ld_prio_load", v, 8'h5A);
    run(0, 8'h90, 0, wd);

    // Latency 3: result must be the fresh one, five cycles after accept.
    load(1, 2'd0, 8'h07);
    load(1, 2'd1, 8'h09);
    run(1, 8'h88, 0, wd);
    check("lat3_add", wd, 8'h10);

    // Load during WAIT is ignored.
    load(1, 2'd3, 8'h21);
    run(1, 8'hA0, 1, wd);
    peek(1, 2'd3, v);
    check("wait_ld_ignored", v, 8'h21);

    // Asynchronous reset in WAIT discards the instruction.
    load(1, 2'd0, 8'h55);
    @(negedge sysclk);
    ins[1] = 8'hA0; iv[1] = 1'b1;
    #1;
    for (int g = 0; g < 50 && !rdy[1]; g++) begin @(negedge sysclk); #1; end
    @(negedge sysclk);
    iv[1] = 1'b0;
    rda[1] = 2'd0;
    #1;
    check("wait_alu_b", b_o[1], 8'h55);
    check("wait_busy", bsy[1], 1);
    #1;
    rstn[1] = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) m[1][r] = '0;
    check("arst_busy", bsy[1], 0);
    check("arst_ready", rdy[1], 0);
    check("arst_alu_b", b_o[1], 0);
    check("arst_rd0", rdd[1], 0);
    seen = 1'b0;
    @(negedge sysclk); seen |= wbv[1];
    @(negedge sysclk); seen |= wbv[1];
    rstn[1] = 1'b1;
    #1;
    check("arst_rel_ready", rdy[1], 1);
    for (int c = 0; c < 6; c++) begin @(negedge sysclk); #1; seen |= wbv[1]; end
    check("arst_no_wb", seen, 0);

    // Randomized instruction stream against the register-file model.
    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 20; it++) begin
        if ($urandom_range(0, 1) == 1) load(d, 2'($urandom_range(0, 3)), 8'($urandom));
        if ($urandom_range(0, 2) == 0) load(d, 2'($urandom_range(0, 3)), 8'($urandom));
        run(d, 8'($urandom), 0, wd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
